// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between fetch and decode.
// First-word-fall-through FIFO of {instruction, pc} pairs with a synchronous
// flush that also discards the next FLUSH_DROP accepted pushes. Those pushes
// are wrong-path fetches that were already in flight when the branch resolved.
//
// Ports:
//   clk_i         sole clock, rising edge
//   reset_i       asynchronous active-low reset
//   flush_i       synchronous flush (highest priority)
//   push_valid_i  fetch offers an entry
//   push_instr_i  offered instruction
//   push_pc_i     offered program counter
//   push_ready_o  queue accepts a push this cycle
//   pop_ready_i   decode consumes the head
//   pop_valid_o   head entry valid
//   pop_instr_o   head instruction (0 when empty)
//   pop_pc_o      head program counter (0 when empty)
//   count_o       stored entries, 0..DEPTH
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FLUSH_DROP = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  input  logic [INSTR_W-1:0]         push_instr_i,
  input  logic [ADDR_W-1:0]          push_pc_i,
  output logic                       push_ready_o,
  input  logic                       pop_ready_i,
  output logic                       pop_valid_o,
  output logic [INSTR_W-1:0]         pop_instr_o,
  output logic [ADDR_W-1:0]          pop_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 2;

  // Storage is data-only; validity is tracked entirely by the control state.
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DROP_W-1:0] drop_cnt;

  logic push_fire;
  logic pop_fire;
  logic dropping;
  logic store;
  logic do_pop;

  // Handshakes; a dropping queue stays ready so wrong-path fetches drain.
  always_comb begin
    dropping     = (drop_cnt != '0);
    push_ready_o = (count < CNT_W'(DEPTH)) || dropping;
    pop_valid_o  = (count != '0);
    push_fire    = push_valid_i && push_ready_o;
    pop_fire     = pop_valid_o && pop_ready_i;
    store        = push_fire && !dropping && !flush_i;
    do_pop       = pop_fire && !flush_i;
  end

  // First-word-fall-through head, forced to zero when empty.
  always_comb begin
    pop_instr_o = '0;
    pop_pc_o    = '0;
    if (pop_valid_o) begin
      pop_instr_o = instr_mem[rd_ptr];
      pop_pc_o    = pc_mem[rd_ptr];
    end
  end

  assign count_o = count;

  // Storage write, no reset.
  always_ff @(posedge clk_i) begin
    if (store) begin
      instr_mem[wr_ptr] <= push_instr_i;
      pc_mem[wr_ptr]    <= push_pc_i;
    end
  end

  // Control state; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= DROP_W'(FLUSH_DROP);
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({store, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A discarded push consumes one drop credit.
      if (push_fire && dropping) begin
        drop_cnt <= drop_cnt - DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven bench for fetch_queue (DEPTH = 4).
// A second instance with FLUSH_DROP = 0 shares the inputs and is checked only
// right after a flush, where both instances start from the same empty state.
module tb_fetch_queue;

  logic        clk_i;
  logic        reset_i;
  logic        flush_i;
  logic        push_valid_i;
  logic [15:0] push_instr_i;
  logic [31:0] push_pc_i;
  logic        pop_ready_i;

  logic        push_ready_o;
  logic        pop_valid_o;
  logic [15:0] pop_instr_o;
  logic [31:0] pop_pc_o;
  logic [2:0]  count_o;

  logic        push_ready_z;
  logic        pop_valid_z;
  logic [15:0] pop_instr_z;
  logic [31:0] pop_pc_z;
  logic [2:0]  count_z;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .INSTR_W(16), .ADDR_W(32), .FLUSH_DROP(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_instr_i(push_instr_i), .push_pc_i(push_pc_i),
    .push_ready_o(push_ready_o), .pop_ready_i(pop_ready_i),
    .pop_valid_o(pop_valid_o), .pop_instr_o(pop_instr_o), .pop_pc_o(pop_pc_o),
    .count_o(count_o)
  );

  fetch_queue #(.DEPTH(4), .INSTR_W(16), .ADDR_W(32), .FLUSH_DROP(0)) dut_nodrop (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_instr_i(push_instr_i), .push_pc_i(push_pc_i),
    .push_ready_o(push_ready_z), .pop_ready_i(pop_ready_i),
    .pop_valid_o(pop_valid_z), .pop_instr_o(pop_instr_z), .pop_pc_o(pop_pc_z),
    .count_o(count_z)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        flush;
    logic        pv;
    logic [15:0] instr;
    logic [31:0] pc;
    logic        pr;
    logic [2:0]  e_cnt;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [31:0] e_pc;
    logic        e_rdy;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  logic [15:0] q_instr [$];
  logic [31:0] q_pc    [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic pv, input logic [15:0] ins,
                       input logic [31:0] pc, input logic pr);
    flush_i      = fl;
    push_valid_i = pv;
    push_instr_i = ins;
    push_pc_i    = pc;
    pop_ready_i  = pr;
  endtask

  // One clock: inputs already driven, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] c, input logic v,
                           input logic [15:0] ins, input logic [31:0] pc, input logic r);
    chk({tag, ".count"},      32'(count_o), 32'(c));
    chk({tag, ".pop_valid"},  32'(pop_valid_o), 32'(v));
    chk({tag, ".pop_instr"},  32'(pop_instr_o), 32'(ins));
    chk({tag, ".pop_pc"},     pop_pc_o, pc);
    chk({tag, ".push_ready"}, 32'(push_ready_o), 32'(r));
  endtask

  initial begin
    // Fill to full, hold a fifth push, drain in order, then single-entry latency.
    vecs[0]  = '{1'b0, 1'b1, 16'h2001, 32'h100, 1'b0, 3'd1, 1'b1, 16'h2001, 32'h100, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 16'h2002, 32'h102, 1'b0, 3'd2, 1'b1, 16'h2001, 32'h100, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 16'h2003, 32'h104, 1'b0, 3'd3, 1'b1, 16'h2001, 32'h100, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 16'h2004, 32'h106, 1'b0, 3'd4, 1'b1, 16'h2001, 32'h100, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h2005, 32'h108, 1'b0, 3'd4, 1'b1, 16'h2001, 32'h100, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h2005, 32'h108, 1'b1, 3'd3, 1'b1, 16'h2002, 32'h102, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 32'h000, 1'b1, 3'd2, 1'b1, 16'h2003, 32'h104, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 32'h000, 1'b1, 3'd1, 1'b1, 16'h2004, 32'h106, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 32'h000, 1'b1, 3'd0, 1'b0, 16'h0000, 32'h000, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h1C08, 32'h010, 1'b1, 3'd1, 1'b1, 16'h1C08, 32'h010, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 32'h000, 1'b1, 3'd0, 1'b0, 16'h0000, 32'h000, 1'b1};
    // Preload two entries for the streaming phase.
    vecs[11] = '{1'b0, 1'b1, 16'hA001, 32'h020, 1'b0, 3'd1, 1'b1, 16'hA001, 32'h020, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 16'hA002, 32'h022, 1'b0, 3'd2, 1'b1, 16'hA001, 32'h020, 1'b1};

    reset_i = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    chk_state("reset", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].flush, vecs[i].pv, vecs[i].instr, vecs[i].pc, vecs[i].pr);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_valid,
                vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_rdy);
    end

    // Streaming: push and pop every cycle against a reference queue.
    q_instr.push_back(16'hA001); q_pc.push_back(32'h020);
    q_instr.push_back(16'hA002); q_pc.push_back(32'h022);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] ni;
      logic [31:0] np;
      ni = 16'hB000 + 16'(i);
      np = 32'h300 + 32'(2 * i);
      drive(1'b0, 1'b1, ni, np, 1'b1);
      step();
      void'(q_instr.pop_front());
      void'(q_pc.pop_front());
      q_instr.push_back(ni);
      q_pc.push_back(np);
      chk_state($sformatf("stream%0d", i), 3'd2, 1'b1, q_instr[0], q_pc[0], 1'b1);
    end

    // Flush with push and pop both active, then one dropped push.
    drive(1'b0, 1'b1, 16'hC001, 32'h400, 1'b0);
    step();
    chk("flush_pre.count", 32'(count_o), 32'd3);
    drive(1'b1, 1'b1, 16'hDEAD, 32'h500, 1'b1);
    step();
    chk_state("flush", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);
    chk("nodrop_flush.count", 32'(count_z), 32'd0);
    drive(1'b0, 1'b1, 16'hBEEF, 32'h204, 1'b0);
    step();
    chk_state("drop_beef", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);
    chk("nodrop_beef.count", 32'(count_z), 32'd1);
    chk("nodrop_beef.pop_instr", 32'(pop_instr_z), 32'hBEEF);
    chk("nodrop_beef.pop_pc", pop_pc_z, 32'h204);
    drive(1'b0, 1'b1, 16'h4601, 32'h200, 1'b0);
    step();
    chk_state("after_drop", 3'd1, 1'b1, 16'h4601, 32'h200, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    step();
    chk_state("after_drop_pop", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Back-to-back flush, then A dropped, B and C kept.
    drive(1'b1, 1'b1, 16'h9999, 32'h590, 1'b0);
    step();
    drive(1'b1, 1'b1, 16'h9998, 32'h592, 1'b0);
    step();
    chk("b2b.count", 32'(count_o), 32'd0);
    drive(1'b0, 1'b1, 16'hAAAA, 32'h600, 1'b0);
    step();
    chk_state("b2b_a", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 16'hBBBB, 32'h602, 1'b0);
    step();
    chk_state("b2b_b", 3'd1, 1'b1, 16'hBBBB, 32'h602, 1'b1);
    drive(1'b0, 1'b1, 16'hCCCC, 32'h604, 1'b0);
    step();
    chk_state("b2b_c", 3'd2, 1'b1, 16'hBBBB, 32'h602, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    step();
    chk_state("b2b_pop1", 3'd1, 1'b1, 16'hCCCC, 32'h604, 1'b1);
    step();
    chk_state("b2b_pop2", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);

    // Asynchronous reset between edges with three stored entries.
    drive(1'b0, 1'b1, 16'h1111, 32'h610, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'h2222, 32'h612, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'h3333, 32'h614, 1'b0);
    step();
    chk("rst_pre.count", 32'(count_o), 32'd3);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #2;
    reset_i = 1'b0;
    #1;
    chk_state("rst_mid", 3'd0, 1'b0, 16'h0, 32'h0, 1'b1);
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(1'b0, 1'b1, 16'h5555, 32'h700, 1'b0);
    step();
    chk_state("rst_after", 3'd1, 1'b1, 16'h5555, 32'h700, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be DEPTH (default 4; queue entries; power of two, >= 2), INSTR_W (default 16; instruction width), ADDR_W (default 32; program-counter width), FLUSH_DROP (default 1; pushes discarded after a flush; range 0..3).
REQ-002 Ports SHALL be as follows; the design SHALL use one clock, and reset SHALL be asynchronous and active-low:
REQ-003 clk_i  in  1  sole clock, all state on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 flush_i  in  1  synchronous pipeline flush (branch taken / branch from WB).
REQ-006 push_valid_i  in  1  fetch stage offers an instruction.
REQ-007 push_instr_i  in  INSTR_W  offered instruction.
REQ-008 push_pc_i  in  ADDR_W  program counter of offered instruction.
REQ-009 push_ready_o  out  1  queue accepts a push this cycle.
REQ-010 pop_ready_i  in  1  decode consumes head (decode not stalled).
REQ-011 pop_valid_o  out  1  head entry valid.
REQ-012 pop_instr_o  out  INSTR_W  head instruction.
REQ-013 pop_pc_o  out  ADDR_W  head program counter.
REQ-014 count_o  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH.

Function
REQ-015 Push handshake: accepted iff push_valid_i && push_ready_o at a rising edge; pop handshake: iff pop_valid_o && pop_ready_i.
REQ-016 push_ready_o SHALL be (count_o < DEPTH) || (drop counter != 0); no combinational path from pop_ready_i.
REQ-017 pop_valid_o SHALL be (count_o != 0); first-word-fall-through: head visible combinationally from storage.
REQ-018 When pop_valid_o = 0, pop_instr_o and pop_pc_o SHALL be driven to 0.
REQ-019 Latency: an entry pushed into an empty queue at edge N SHALL appear with pop_valid_o = 1 after edge N (same cycle as count_o = 1).
REQ-020 Order SHALL be strict FIFO; instruction and PC of an entry SHALL remain paired.
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 Simultaneous accepted push and pop SHALL leave count_o unchanged and advance both pointers, including at count = DEPTH-1; at count = DEPTH, push_ready_o = 0 (unless dropping) so only the pop occurs.
REQ-023 flush_i = 1 at an edge SHALL have priority: pointers and count -> 0, any push/pop in that cycle ignored, drop counter loaded with FLUSH_DROP.
REQ-024 While the drop counter is non-zero, each accepted push SHALL be discarded (not stored) and decrement the counter; count_o unchanged by the push; pops proceed normally.
REQ-025 flush_i while the drop counter is non-zero SHALL reload it with FLUSH_DROP.
REQ-026 With FLUSH_DROP = 0, the first push after flush SHALL be stored.
REQ-027 Storage array SHALL not be reset; only control state is reset.

Reset
REQ-028 reset_i = 0 SHALL immediately (asynchronously) force pointers = 0, count_o = 0, drop counter = 0, hence pop_valid_o = 0, pop_instr_o = 0, pop_pc_o = 0, push_ready_o = 1.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; first edge after release with push behaves as push into empty queue.

Verification
REQ-030 Reset mid-run: count_o = 3, drive reset_i = 0 between edges -> count_o = 0, pop_valid_o = 0, push_ready_o = 1 before next edge.
REQ-031 Fill, DEPTH = 4, pop_ready_i = 0: push 0x2001..0x2005 with PCs 0x100..0x108 -> after 4 edges count_o = 4, push_ready_o = 0, 5th held; then pop_ready_i = 1 -> 0x2001/0x100 .. 0x2004/0x106 in order.
REQ-032 Streaming: count_o = 2, push and pop every cycle for 10 cycles -> count_o stays 2, pointers wrap, outputs match a reference FIFO model.
REQ-033 Flush, FLUSH_DROP = 1: count_o = 3, flush_i = 1 with push and pop active -> next cycle count_o = 0, pop_valid_o = 0; next push 0xBEEF discarded; following push 0x4601/PC 0x200 popped one cycle later.
REQ-034 Back-to-back flush: flush_i on two consecutive cycles then three pushes A, B, C -> A dropped, B and C stored in order.
REQ-035 Latency: empty queue, single push 0x1C08 at edge N -> pop_valid_o = 1, pop_instr_o = 0x1C08 after edge N; with pop_ready_i = 1, queue empty after edge N+1.
